// File: rtl/plab4_net_router_output_terminal_demux_notp_pkg.sv
// ----------------------------------------------------------------------------
// plab4_net_router_output_terminal_demux_notp_pkg
// Shared plab4-net message header: domain encodings and default widths.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package plab4_net_router_output_terminal_demux_notp_pkg;

  typedef enum logic {
    DOMAIN_D0 = 1'b0,
    DOMAIN_D1 = 1'b1
  } domain_e;

  localparam int MSG_NBITS         = 44;
  localparam int DEFAULT_ENTRIES   = 2;
  localparam int DEFAULT_FREE_BITS = 2;

endpackage

`default_nettype wire

// File: rtl/plab4_net_router_output_terminal_demux_notp_if.sv
// ----------------------------------------------------------------------------
// plab4_net_router_output_terminal_demux_notp_if
// Terminal-side handshake bundle: one input stream, two per-domain outputs.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface plab4_net_router_output_terminal_demux_notp_if #(
  parameter int MSG_NBITS  = plab4_net_router_output_terminal_demux_notp_pkg::MSG_NBITS,
  parameter int FREE_NBITS = plab4_net_router_output_terminal_demux_notp_pkg::DEFAULT_FREE_BITS
);
  logic                  in_val;
  logic                  in_rdy;
  logic [MSG_NBITS-1:0]  in_msg;
  logic                  in_domain;
  logic                  out_val_d0;
  logic                  out_rdy_d0;
  logic [MSG_NBITS-1:0]  out_msg_d0;
  logic                  out_val_d1;
  logic                  out_rdy_d1;
  logic [MSG_NBITS-1:0]  out_msg_d1;
  logic [FREE_NBITS-1:0] num_free_d0;
  logic [FREE_NBITS-1:0] num_free_d1;

  modport master (
    output in_val, in_msg, in_domain, out_rdy_d0, out_rdy_d1,
    input  in_rdy, out_val_d0, out_msg_d0, out_val_d1, out_msg_d1,
           num_free_d0, num_free_d1
  );

  modport slave (
    input  in_val, in_msg, in_domain, out_rdy_d0, out_rdy_d1,
    output in_rdy, out_val_d0, out_msg_d0, out_val_d1, out_msg_d1,
           num_free_d0, num_free_d1
  );
endinterface

`default_nettype wire

// File: rtl/plab4_net_router_output_terminal_demux_notp_queue.sv
// ----------------------------------------------------------------------------
// plab4_net_output_terminal_queue
// Per-domain ejection FIFO with registered free-slot count for credit return.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plab4_net_output_terminal_queue
  import plab4_net_router_output_terminal_demux_notp_pkg::*;
#(
  parameter int P_MSG_NBITS      = MSG_NBITS,
  parameter int P_NUM_ENTRIES    = DEFAULT_ENTRIES,
  parameter int P_NUM_FREE_NBITS = DEFAULT_FREE_BITS
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        i_enq_val,
  output logic                             o_enq_rdy,
  input  wire logic [P_MSG_NBITS-1:0]      i_enq_msg,
  output logic                             o_deq_val,
  input  wire logic                        i_deq_rdy,
  output logic [P_MSG_NBITS-1:0]           o_deq_msg,
  output logic [P_NUM_FREE_NBITS-1:0]      o_num_free
);

  localparam int c_PTR_NBITS = $clog2(P_NUM_ENTRIES);
  localparam int c_CNT_NBITS = $clog2(P_NUM_ENTRIES) + 1;
  localparam logic [c_CNT_NBITS-1:0] c_FULL = c_CNT_NBITS'(P_NUM_ENTRIES);

  logic [c_PTR_NBITS-1:0] r_wr_ptr;
  logic [c_PTR_NBITS-1:0] r_rd_ptr;
  logic [c_CNT_NBITS-1:0] r_count;
  logic [P_MSG_NBITS-1:0] r_mem [P_NUM_ENTRIES];
  logic                   w_enq;
  logic                   w_deq;

  // Ready is judged on the pre-dequeue count, so a full queue never takes a
  // new message even when its head leaves in the same cycle.
  assign o_enq_rdy  = (r_count != c_FULL);
  assign o_deq_val  = (r_count != '0);
  assign o_deq_msg  = r_mem[r_rd_ptr];
  assign o_num_free = P_NUM_FREE_NBITS'(c_FULL - r_count);
  assign w_enq      = i_enq_val && o_enq_rdy;
  assign w_deq      = o_deq_val && i_deq_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + c_PTR_NBITS'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + c_PTR_NBITS'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_NBITS'(1);
        2'b01:   r_count <= r_count - c_CNT_NBITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; it is only observed when count != 0.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= i_enq_msg;
  end

endmodule

`default_nettype wire

// File: rtl/plab4_net_router_output_terminal_demux_notp.sv
// ----------------------------------------------------------------------------
// plab4_net_router_output_terminal_demux_notp
// Steers terminal output messages into independent per-domain ejection queues.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plab4_net_router_output_terminal_demux_notp
  import plab4_net_router_output_terminal_demux_notp_pkg::*;
#(
  parameter int P_MSG_NBITS      = MSG_NBITS,
  parameter int P_NUM_ENTRIES    = DEFAULT_ENTRIES,
  parameter int P_NUM_FREE_NBITS = DEFAULT_FREE_BITS
) (
  input wire logic clk,
  input wire logic rst_n,
  plab4_net_router_output_terminal_demux_notp_if.slave io_net
);

  logic w_sel_d0;
  logic w_sel_d1;
  logic w_rdy_d0;
  logic w_rdy_d1;

  assign w_sel_d0      = io_net.in_val && (io_net.in_domain == DOMAIN_D0);
  assign w_sel_d1      = io_net.in_val && (io_net.in_domain == DOMAIN_D1);
  assign io_net.in_rdy = (io_net.in_domain == DOMAIN_D1) ? w_rdy_d1 : w_rdy_d0;

  plab4_net_output_terminal_queue #(
    .P_MSG_NBITS      (P_MSG_NBITS),
    .P_NUM_ENTRIES    (P_NUM_ENTRIES),
    .P_NUM_FREE_NBITS (P_NUM_FREE_NBITS)
  ) u_queue_d0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enq_val  (w_sel_d0),
    .o_enq_rdy  (w_rdy_d0),
    .i_enq_msg  (io_net.in_msg),
    .o_deq_val  (io_net.out_val_d0),
    .i_deq_rdy  (io_net.out_rdy_d0),
    .o_deq_msg  (io_net.out_msg_d0),
    .o_num_free (io_net.num_free_d0)
  );

  plab4_net_output_terminal_queue #(
    .P_MSG_NBITS      (P_MSG_NBITS),
    .P_NUM_ENTRIES    (P_NUM_ENTRIES),
    .P_NUM_FREE_NBITS (P_NUM_FREE_NBITS)
  ) u_queue_d1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_enq_val  (w_sel_d1),
    .o_enq_rdy  (w_rdy_d1),
    .i_enq_msg  (io_net.in_msg),
    .o_deq_val  (io_net.out_val_d1),
    .i_deq_rdy  (io_net.out_rdy_d1),
    .o_deq_msg  (io_net.out_msg_d1),
    .o_num_free (io_net.num_free_d1)
  );

endmodule

`default_nettype wire

// File: tb/tb_plab4_net_router_output_terminal_demux_notp.sv
// ----------------------------------------------------------------------------
// tb_plab4_net_router_output_terminal_demux_notp
// Directed and random traffic compared against a two-queue reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_plab4_net_router_output_terminal_demux_notp;

  localparam int c_MSG_NBITS = 44;
  localparam int c_ENTRIES   = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [c_MSG_NBITS-1:0] mq0[$];
  logic [c_MSG_NBITS-1:0] mq1[$];

  plab4_net_router_output_terminal_demux_notp_if #(.MSG_NBITS(c_MSG_NBITS), .FREE_NBITS(2)) net_if ();

  plab4_net_router_output_terminal_demux_notp #(
    .P_MSG_NBITS      (c_MSG_NBITS),
    .P_NUM_ENTRIES    (c_ENTRIES),
    .P_NUM_FREE_NBITS (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_net (net_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Compares all outputs against the model, then advances the model by one edge.
  task automatic step(input logic v, input logic dom, input logic [c_MSG_NBITS-1:0] msg,
                      input logic r0, input logic r1);
    logic acc;
    logic deq0;
    logic deq1;
    int   sz_dom;
    @(negedge clk);
    net_if.in_val     = v;
    net_if.in_domain  = dom;
    net_if.in_msg     = msg;
    net_if.out_rdy_d0 = r0;
    net_if.out_rdy_d1 = r1;
    #1;
    sz_dom = dom ? mq1.size() : mq0.size();
    chk("in_rdy",      64'(net_if.in_rdy),      64'(sz_dom < c_ENTRIES));
    chk("out_val_d0",  64'(net_if.out_val_d0),  64'(mq0.size() != 0));
    chk("out_val_d1",  64'(net_if.out_val_d1),  64'(mq1.size() != 0));
    chk("num_free_d0", 64'(net_if.num_free_d0), 64'(c_ENTRIES - mq0.size()));
    chk("num_free_d1", 64'(net_if.num_free_d1), 64'(c_ENTRIES - mq1.size()));
    if (mq0.size() != 0) chk("out_msg_d0", 64'(net_if.out_msg_d0), 64'(mq0[0]));
    if (mq1.size() != 0) chk("out_msg_d1", 64'(net_if.out_msg_d1), 64'(mq1[0]));
    acc  = v && (sz_dom < c_ENTRIES);
    deq0 = r0 && (mq0.size() != 0);
    deq1 = r1 && (mq1.size() != 0);
    @(posedge clk);
    if (deq0) void'(mq0.pop_front());
    if (deq1) void'(mq1.pop_front());
    if (acc) begin
      if (dom) mq1.push_back(msg);
      else     mq0.push_back(msg);
    end
  endtask

  initial begin
    logic [c_MSG_NBITS-1:0] m;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    net_if.in_val = 1'b0;
    net_if.in_domain = 1'b0;
    net_if.in_msg = '0;
    net_if.out_rdy_d0 = 1'b0;
    net_if.out_rdy_d1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val_d0",  64'(net_if.out_val_d0),  64'(0));
    chk("rst_out_val_d1",  64'(net_if.out_val_d1),  64'(0));
    chk("rst_num_free_d0", 64'(net_if.num_free_d0), 64'(2));
    chk("rst_num_free_d1", 64'(net_if.num_free_d1), 64'(2));
    chk("rst_in_rdy",      64'(net_if.in_rdy),      64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Single message into d0, visible next cycle only
    step(1'b1, 1'b0, 44'hA1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 44'h0,  1'b1, 1'b0);
    step(1'b0, 1'b0, 44'h0,  1'b0, 1'b0);

    // Fill d0, stall it, then d1 must still flow
    step(1'b1, 1'b0, 44'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 44'h22, 1'b0, 1'b0);
    step(1'b1, 1'b0, 44'h33, 1'b0, 1'b0);
    step(1'b1, 1'b1, 44'h44, 1'b0, 1'b0);
    // Full d0 with simultaneous dequeue: 0x33 must wait one cycle
    step(1'b1, 1'b0, 44'h33, 1'b1, 1'b0);
    step(1'b1, 1'b0, 44'h33, 1'b1, 1'b0);
    step(1'b0, 1'b0, 44'h0,  1'b1, 1'b0);
    step(1'b0, 1'b0, 44'h0,  1'b1, 1'b0);

    // d1 holds 0x44; enqueue and dequeue together, then six back-to-back
    step(1'b1, 1'b1, 44'h55, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 44'(60 + i), 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 44'h0, 1'b1, 1'b1);

    // Asynchronous reset with both queues full
    step(1'b1, 1'b0, 44'hB0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 44'hB1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 44'hC0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 44'hC1, 1'b0, 1'b0);
    #2;
    net_if.in_val = 1'b0;
    net_if.out_rdy_d0 = 1'b1;
    net_if.out_rdy_d1 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_val_d0",  64'(net_if.out_val_d0),  64'(0));
    chk("arst_out_val_d1",  64'(net_if.out_val_d1),  64'(0));
    chk("arst_num_free_d0", 64'(net_if.num_free_d0), 64'(2));
    chk("arst_num_free_d1", 64'(net_if.num_free_d1), 64'(2));
    mq0.delete();
    mq1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 44'h0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      m = 44'({$urandom(), $urandom()});
      step(1'($urandom_range(0, 3) != 0), 1'($urandom()), m,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
